// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load funct3 values and the stage FSM states.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Load data alignment: picks the addressed lane out of the raw memory
// word and sign- or zero-extends it to XLEN.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [2:0]      off;
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    logic [XLEN-1:0] sh_w;

    always_comb begin
        // Byte offset within the bus word; bit 2 only exists on a 64-bit bus.
        off  = {addr_lo_i[2] & (XLEN == 64), addr_lo_i[1:0]};
        sh_b = rdata_i >> {off, 3'b000};
        sh_h = rdata_i >> {off[2:1], 4'b0000};
        sh_w = rdata_i >> {off[2], 5'b00000};
        data_o = '0;
        case (funct3_i)
            F3_LB:  data_o = XLEN'($signed(sh_b[7:0]));
            F3_LBU: data_o = XLEN'(sh_b[7:0]);
            F3_LH:  data_o = XLEN'($signed(sh_h[15:0]));
            F3_LHU: data_o = XLEN'(sh_h[15:0]);
            F3_LW:  data_o = XLEN'($signed(sh_w[31:0]));
            F3_LD:  data_o = (XLEN == 64) ? rdata_i : '0;
            F3_LWU: data_o = (XLEN == 64) ? XLEN'(sh_w[31:0]) : '0;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: selects the writeback source, aligns load data and
// stalls MEM while a variable-latency load response is outstanding.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [2:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  retire_count,
    output logic              err_rvalid
);

    wb_state_e         state_q;
    logic [REG_AW-1:0] rd_q;
    logic              rw_q;
    logic [2:0]        f3_q;
    logic [2:0]        addr_q;

    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [XLEN-1:0]   rf_wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic              idle;
    logic              accept;
    logic              is_load;
    logic              done_d;
    logic              park_d;
    logic              stray_d;
    logic [2:0]        al_f3;
    logic [2:0]        al_addr;
    logic [XLEN-1:0]   load_data;
    logic [REG_AW-1:0] rf_waddr_d;
    logic              rw_d;
    logic [XLEN-1:0]   rf_wdata_d;

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .rdata_i  (mem_rdata),
        .funct3_i (al_f3),
        .addr_lo_i(al_addr),
        .data_o   (load_data)
    );

    always_comb begin
        idle    = (state_q == IDLE);
        accept  = idle & in_valid & ~flush;
        is_load = (in_wb_sel == WB_SEL_LOAD);
        // A parked load uses its captured context, not the live inputs.
        al_f3   = idle ? in_funct3 : f3_q;
        al_addr = idle ? in_addr_lo : addr_q;
        done_d  = idle ? (accept & (~is_load | mem_rvalid)) : mem_rvalid;
        park_d  = accept & is_load & ~mem_rvalid;
        stray_d = idle & mem_rvalid & ~(accept & is_load);
        rf_waddr_d = idle ? in_rd : rd_q;
        rw_d       = idle ? in_reg_write : rw_q;
        rf_wdata_d = '0;
        if (!idle) begin
            rf_wdata_d = load_data;
        end else begin
            case (in_wb_sel)
                WB_SEL_ALU:  rf_wdata_d = in_alu_result;
                WB_SEL_LOAD: rf_wdata_d = load_data;
                WB_SEL_PC4:  rf_wdata_d = in_pc_plus4;
                default:     rf_wdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (park_d) begin
                        state_q <= WAIT_LOAD;
                        rd_q    <= in_rd;
                        rw_q    <= in_reg_write;
                        f3_q    <= in_funct3;
                        addr_q  <= in_addr_lo;
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            rf_we_q <= done_d & rw_d & (rf_waddr_d != '0);
            if (done_d) begin
                rf_waddr_q <= rf_waddr_d;
                rf_wdata_q <= rf_wdata_d;
                cnt_q      <= cnt_q + CNT_W'(1);
            end
            if (stray_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q == WAIT_LOAD);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = cnt_q;
    assign err_rvalid   = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: a 32-bit and a 64-bit instance share one stimulus
// stream; expected writes are queued at issue and checked on retirement.
module tb_wb_unit;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_funct3 = '0;
    logic [2:0]  in_addr_lo = '0;
    logic [63:0] in_alu = '0;
    logic [63:0] in_pc4 = '0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        rdy32, busy32, we32, err32;
    logic [4:0]  wa32;
    logic [31:0] wd32, rc32;
    logic        rdy64, busy64, we64, err64;
    logic [4:0]  wa64;
    logic [63:0] wd64;
    logic [31:0] rc64;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy32), .flush(flush),
        .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu[31:0]), .in_pc_plus4(in_pc4[31:0]),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
        .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
        .busy(busy32), .retire_count(rc32), .err_rvalid(err32)
    );

    wb_unit #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy64), .flush(flush),
        .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu), .in_pc_plus4(in_pc4),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
        .busy(busy64), .retire_count(rc64), .err_rvalid(err64)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d32;
        logic [63:0] d64;
    } exp_t;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [2:0]  a;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [63:0] rdata;
        logic        we;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    exp_t sb[$];
    vec_t vt[15];
    int   tests = 0;
    int   fails = 0;
    int   nret = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic rw,
                         input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [2:0] a,
                         input logic [63:0] alu, input logic [63:0] pc4,
                         input logic rv, input logic [63:0] rdata);
        @(negedge clk);
        in_valid     = v;
        flush        = fl;
        in_reg_write = rw;
        in_rd        = rd;
        in_wb_sel    = sel;
        in_funct3    = f3;
        in_addr_lo   = a;
        in_alu       = alu;
        in_pc4       = pc4;
        mem_rvalid   = rv;
        mem_rdata    = rdata;
    endtask

    task automatic idle_cyc();
        drive(0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 64'd0, 64'd0, 0, 64'd0);
    endtask

    task automatic push(input logic we, input logic [4:0] wa,
                        input logic [31:0] d32, input logic [63:0] d64);
        exp_t e;
        e.we = we;
        e.wa = wa;
        e.d32 = d32;
        e.d64 = d64;
        sb.push_back(e);
    endtask

    // Retirement monitor: a count step pops one expected write.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            nret = 0;
        end else if (rc32 == nret + 1) begin
            nret++;
            chk("rc64", 64'(rc64), 64'(nret));
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_retire: got count %0d want %0d",
                         rc32, nret - 1);
            end else begin
                e = sb.pop_front();
                chk("we32", 64'(we32), 64'(e.we));
                chk("waddr32", 64'(wa32), 64'(e.wa));
                chk("wdata32", 64'(wd32), 64'(e.d32));
                chk("we64", 64'(we64), 64'(e.we));
                chk("waddr64", 64'(wa64), 64'(e.wa));
                chk("wdata64", wd64, e.d64);
            end
        end else begin
            chk("count32", 64'(rc32), 64'(nret));
            chk("count64", 64'(rc64), 64'(nret));
            chk("idle_we32", 64'(we32), 64'd0);
            chk("idle_we64", 64'(we64), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 5'd1,  WB_SEL_LOAD, F3_LB,  3'd3, 64'd0, 64'd0,
                   64'h0000_0000_8000_0000, 1,
                   32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
        vt[1]  = '{1, 5'd2,  WB_SEL_LOAD, F3_LHU, 3'd2, 64'd0, 64'd0,
                   64'h0000_0000_BEEF_1234, 1,
                   32'h0000_BEEF, 64'h0000_0000_0000_BEEF};
        vt[2]  = '{1, 5'd3,  WB_SEL_LOAD, F3_LH,  3'd2, 64'd0, 64'd0,
                   64'h0000_0000_BEEF_1234, 1,
                   32'hFFFF_BEEF, 64'hFFFF_FFFF_FFFF_BEEF};
        vt[3]  = '{1, 5'd4,  WB_SEL_LOAD, F3_LD,  3'd0, 64'd0, 64'd0,
                   64'h1234_5678_9ABC_DEF0, 1,
                   32'h0, 64'h1234_5678_9ABC_DEF0};
        vt[4]  = '{1, 5'd5,  WB_SEL_LOAD, F3_LWU, 3'd4, 64'd0, 64'd0,
                   64'hF000_0000_0000_0000, 1,
                   32'h0, 64'h0000_0000_F000_0000};
        vt[5]  = '{1, 5'd6,  WB_SEL_LOAD, F3_LW,  3'd4, 64'd0, 64'd0,
                   64'hF000_0000_0000_0000, 1,
                   32'h0, 64'hFFFF_FFFF_F000_0000};
        vt[6]  = '{1, 5'd0,  WB_SEL_ALU,  3'd0,   3'd0, 64'd5, 64'd0,
                   64'd0, 0, 32'd5, 64'd5};
        vt[7]  = '{1, 5'd7,  WB_SEL_ALU,  3'd0,   3'd0, 64'd9, 64'd0,
                   64'd0, 1, 32'd9, 64'd9};
        vt[8]  = '{1, 5'd8,  WB_SEL_PC4,  3'd0,   3'd0, 64'd1,
                   64'h1111_0000_0000_1004, 64'd0, 1,
                   32'h0000_1004, 64'h1111_0000_0000_1004};
        vt[9]  = '{1, 5'd9,  2'b11,       3'd0,   3'd0, 64'h55, 64'h66,
                   64'd0, 1, 32'd0, 64'd0};
        vt[10] = '{0, 5'd10, WB_SEL_ALU,  3'd0,   3'd0, 64'h77, 64'd0,
                   64'd0, 0, 32'h77, 64'h77};
        vt[11] = '{1, 5'd11, WB_SEL_LOAD, F3_LBU, 3'd1, 64'd0, 64'd0,
                   64'hFFFF_FFFF_FFFF_A5FF, 1, 32'hA5, 64'hA5};
        vt[12] = '{1, 5'd12, WB_SEL_LOAD, F3_LB,  3'd5, 64'd0, 64'd0,
                   64'h0000_7F00_0000_0000, 1, 32'h0, 64'h7F};
        vt[13] = '{1, 5'd13, WB_SEL_LOAD, F3_LH,  3'd3, 64'd0, 64'd0,
                   64'h0000_0000_8001_0000, 1,
                   32'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
        vt[14] = '{1, 5'd14, WB_SEL_LOAD, 3'b111, 3'd0, 64'd0, 64'd0,
                   64'h1234, 1, 32'h0, 64'h0};

        repeat (2) @(negedge clk);
        chk("rst_we", 64'(we32), 64'd0);
        chk("rst_waddr", 64'(wa64), 64'd0);
        chk("rst_wdata", wd64, 64'd0);
        chk("rst_count", 64'(rc32), 64'd0);
        chk("rst_err", 64'(err32), 64'd0);
        rst_n = 1'b1;
        chk("rst_ready", 64'(rdy32), 64'd1);
        chk("rst_busy", 64'(busy64), 64'd0);

        for (int i = 0; i < 15; i++) begin
            drive(1, 0, vt[i].rw, vt[i].rd, vt[i].sel, vt[i].f3, vt[i].a,
                  vt[i].alu, vt[i].pc4, vt[i].sel == WB_SEL_LOAD,
                  vt[i].rdata);
            push(vt[i].we, vt[i].rd, vt[i].e32, vt[i].e64);
        end
        idle_cyc();
        chk("no_err32", 64'(err32), 64'd0);
        chk("no_err64", 64'(err64), 64'd0);

        // Parked load; a held ALU op must be ignored while waiting.
        drive(1, 0, 1, 5'd16, WB_SEL_LOAD, F3_LBU, 3'd2, 64'd0, 64'd0,
              0, 64'd0);
        push(1, 5'd16, 32'hC3, 64'hC3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 5'd17, WB_SEL_ALU, 3'd0, 3'd0, 64'hDEAD, 64'd0,
                  i == 2, 64'h0000_0000_00C3_0000);
            chk("wait_busy32", 64'(busy32), 64'd1);
            chk("wait_ready32", 64'(rdy32), 64'd0);
            chk("wait_busy64", 64'(busy64), 64'd1);
            chk("wait_ready64", 64'(rdy64), 64'd0);
        end
        drive(1, 0, 1, 5'd18, WB_SEL_ALU, 3'd0, 3'd0, 64'h42, 64'd0,
              0, 64'd0);
        push(1, 5'd18, 32'h42, 64'h42);
        chk("after_rv_ready", 64'(rdy32), 64'd1);
        chk("after_rv_busy", 64'(busy32), 64'd0);

        drive(1, 1, 1, 5'd19, WB_SEL_ALU, 3'd0, 3'd0, 64'h99, 64'd0,
              0, 64'd0);
        idle_cyc();
        drive(0, 0, 0, 5'd0, WB_SEL_ALU, 3'd0, 3'd0, 64'd0, 64'd0,
              1, 64'd0);
        idle_cyc();
        chk("err32_set", 64'(err32), 64'd1);
        chk("err64_set", 64'(err64), 64'd1);
        idle_cyc();
        idle_cyc();
        chk("err32_sticky", 64'(err32), 64'd1);

        drive(1, 0, 1, 5'd20, WB_SEL_LOAD, F3_LW, 3'd0, 64'd0, 64'd0,
              0, 64'd0);
        idle_cyc();
        chk("pre_rst_busy", 64'(busy32), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy32), 64'd0);
        chk("mid_rst_count", 64'(rc64), 64'd0);
        chk("mid_rst_waddr", 64'(wa32), 64'd0);
        chk("mid_rst_wdata", 64'(wd32), 64'd0);
        chk("mid_rst_err", 64'(err64), 64'd0);
        rst_n = 1'b1;
        chk("mid_rst_ready", 64'(rdy64), 64'd1);
        idle_cyc();
        drive(1, 0, 1, 5'd21, WB_SEL_ALU, 3'd0, 3'd0, 64'h3, 64'd0,
              0, 64'd0);
        push(1, 5'd21, 32'h3, 64'h3);
        idle_cyc();
        idle_cyc();
        chk("final_count32", 64'(rc32), 64'd1);
        chk("final_count64", 64'(rc64), 64'd1);
        chk("final_err32", 64'(err32), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
Parametrised writeback stage for the pipelined RV core, sitting between the MEM stage and the register file. It accepts one instruction per cycle and aligns and extends load data by byte offset. It selects the writeback source (ALU, load, PC+4) and drives a registered register-file write port. It also supports variable-latency data memory by holding the stage in a load-wait state and back-pressuring MEM until the load response arrives.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register address width.
CNT_W, 32, width of retire counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  MEM stage presents an instruction.
in_ready  output  1  WB can accept this cycle.
flush  input  1  kills the instruction presented this cycle.
in_reg_write  input  1  instruction writes rd.
in_rd  input  REG_AW  destination register.
in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved.
in_funct3  input  3  load type.
in_addr_lo  input  3  low bits of load address (bit 2 ignored when XLEN=32).
in_alu_result  input  XLEN  ALU result.
in_pc_plus4  input  XLEN  link value.
mem_rvalid  input  1  load data valid.
mem_rdata  input  XLEN  raw memory word.
rf_we  output  1  register-file write enable.
rf_waddr  output  REG_AW  write address.
rf_wdata  output  XLEN  write data.
busy  output  1  high in WAIT_LOAD.
retire_count  output  CNT_W  completed instructions, wraps.
err_rvalid  output  1  sticky: mem_rvalid seen with no load outstanding.

Behaviour:
- Reset: all outputs, captured context and counter are 0; FSM goes to IDLE. in_ready=1 after reset release.
- FSM IDLE: in_ready=1. Accept = in_valid & ~flush.
  - Non-load accept: complete next cycle.
  - Load accept with mem_rvalid in the same cycle: complete next cycle.
  - Load accept without mem_rvalid: capture rd, reg_write, funct3 and addr_lo, then go to WAIT_LOAD.
- FSM WAIT_LOAD: in_ready=0, busy=1, and in_valid is ignored.
  - On mem_rvalid: complete next cycle and return to IDLE.
  - A new instruction can be accepted in the cycle after rvalid.
- Flush: affects only the instruction presented in that cycle. An outstanding load in WAIT_LOAD is never cancelled.
- Completion (registered, one cycle after the decision edge):
  - rf_we = reg_write & (rd != 0); rf_waddr = rd; rf_wdata = selected value.
  - retire_count increments by 1, including for rd=0 and reg_write=0.
  - With no completion, rf_we=0; rf_waddr and rf_wdata hold their last values.
- Load alignment:
  - Lane offset = addr_lo modulo (XLEN/8), forced down to the natural alignment of the access size.
  - funct3 000 LB, 100 LBU: byte. 001 LH, 101 LHU: half. 010 LW: word. The signed forms sign-extend to XLEN; the U forms zero-extend.
  - XLEN=64 only: 011 LD, full word; 110 LWU, zero-extended word.
  - Any other funct3 (including LD/LWU when XLEN=32) writes 0.
- in_wb_sel=11 writes 0.
- err_rvalid: set when mem_rvalid is high in IDLE without a simultaneous load accept. Cleared only by reset.
- Reset asserted mid-WAIT_LOAD: returns to IDLE and the pending write is dropped.
- Latency: one cycle from accept, or from rvalid, to the rf write. Throughput is one instruction per cycle for non-loads and zero-wait loads.

Decomposition:
- Package wb_pkg:
  - WB_SEL_ALU, WB_SEL_LOAD, WB_SEL_PC4 constants.
  - funct3 load encodings (F3_LB … F3_LWU).
  - FSM state typedef (IDLE, WAIT_LOAD).
- Sub-module load_align (combinational): XLEN parameter; inputs rdata, funct3, addr_lo; output extended data.

Test Plan:
- LB, addr_lo=3, mem_rdata=0x80_00_00_00, zero-wait -> next cycle rf_we=1, rf_wdata=0xFFFFFF80; retire_count=1.
- LHU, addr_lo=2, rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF. Same with LH -> 0xFFFFBEEF.
- Load accepted, mem_rvalid 3 cycles later:
  - in_ready=0 and busy=1 for 3 cycles; a held in_valid is not accepted.
  - The write lands in the cycle after rvalid; in_ready=1 from that cycle.
- Back-to-back ALU ops: first with rd=0, in_alu_result=5; second with rd=7, result 9.
  - First op: no rf_we.
  - Second op: rf_we=1, waddr=7, wdata=9.
  - retire_count=2.
- Flush: in_valid with flush=1 -> no write, no count. mem_rvalid pulse in IDLE -> err_rvalid=1 and stays 1.
- XLEN=64:
  - LD -> full 64-bit word written.
  - LWU at addr_lo=4, rdata=0xF0000000_00000000 -> 0x00000000_F0000000.
  - LW of the same data and offset -> 0xFFFFFFFF_F0000000.
